// File: rtl/m68k_bus_responder_if.sv
// 68000 CPU bus as seen by the responder: strobes, address and function code in,
// reset/DTACK/BERR and read data out.
interface m68k_bus_responder_if;
   logic        m68k_AS_n;
   logic        m68k_UDS_n;
   logic        m68k_LDS_n;
   logic        m68k_RW;
   logic [23:0] m68k_A;
   logic [2:0]  m68k_FC;
   logic        m68k_RESET_in;
   logic        m68k_DTACK_n;
   logic        m68k_BERR_n;
   logic [15:0] m68k_D_out;
   logic [1:0]  m68k_D_oe;

   modport master (
      output m68k_AS_n, m68k_UDS_n, m68k_LDS_n, m68k_RW,
      output m68k_A, m68k_FC,
      input  m68k_RESET_in, m68k_DTACK_n, m68k_BERR_n,
      input  m68k_D_out, m68k_D_oe
   );

   modport slave (
      input  m68k_AS_n, m68k_UDS_n, m68k_LDS_n, m68k_RW,
      input  m68k_A, m68k_FC,
      output m68k_RESET_in, m68k_DTACK_n, m68k_BERR_n,
      output m68k_D_out, m68k_D_oe
   );
endinterface

// File: rtl/m68k_bus_responder.sv
// Minimal 68000 bus slave: holds the CPU in reset at startup, then answers every
// bus cycle with DTACK (reads return a fixed word) or BERR on timeout.
module m68k_bus_responder #(
   parameter int          RESET_DELAY_BITS = 24,
   parameter int          DTACK_WAIT       = 0,
   parameter int          BERR_TIMEOUT     = 1024,
   parameter logic [15:0] DATA_WORD        = 16'h4E71
) (
   input  logic        clk_sys,
   input  logic        rst,
   m68k_bus_responder_if.slave bus,
   input  logic        dtack_en,
   input  logic [1:0]  led_sel,
   output logic [23:0] last_addr,
   output logic [2:0]  last_fc,
   output logic [31:0] cycle_count,
   output logic        berr_flag,
   output logic [7:0]  led
);

   localparam int TW = $clog2(BERR_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ACK,
      BERR
   } state_t;

   state_t state, state_nx;

   logic [1:0] as_sy, uds_sy, lds_sy, rw_sy;
   logic       as_d;
   logic       as_s, uds_s, lds_s, rw_s;

   logic [RESET_DELAY_BITS-1:0] start_cnt;
   logic                        start_done;

   logic [7:0]    wait_cnt, wait_nx;
   logic [TW-1:0] to_cnt, to_nx;
   logic          rw_lat;
   logic          cap, berr_set, count_inc;

   logic        dtack_n, berr_n;
   logic [15:0] d_out;
   logic [1:0]  d_oe;
   logic [7:0]  led_nx;

   assign as_s  = as_sy[1];
   assign uds_s = uds_sy[1];
   assign lds_s = lds_sy[1];
   assign rw_s  = rw_sy[1];

   // Strobes come straight from the CPU; everything below uses these copies.
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         as_sy  <= 2'b11;
         uds_sy <= 2'b11;
         lds_sy <= 2'b11;
         rw_sy  <= 2'b11;
         as_d   <= 1'b1;
      end else begin
         as_sy  <= {as_sy[0], bus.m68k_AS_n};
         uds_sy <= {uds_sy[0], bus.m68k_UDS_n};
         lds_sy <= {lds_sy[0], bus.m68k_LDS_n};
         rw_sy  <= {rw_sy[0], bus.m68k_RW};
         as_d   <= as_s;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         start_cnt  <= '0;
         start_done <= 1'b0;
      end else if (!start_done) begin
         start_cnt <= start_cnt + RESET_DELAY_BITS'(1);
         if (&start_cnt) start_done <= 1'b1;
      end
   end

   assign bus.m68k_RESET_in = ~start_done;

   always_comb begin
      state_nx  = state;
      wait_nx   = wait_cnt;
      to_nx     = to_cnt;
      cap       = 1'b0;
      berr_set  = 1'b0;
      count_inc = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_done && as_d && !as_s) begin
               state_nx = WAIT;
               cap      = 1'b1;
               wait_nx  = 8'(DTACK_WAIT);
               to_nx    = '0;
            end
         end
         WAIT: begin
            // An aborted cycle wins over both acknowledge and timeout.
            if (as_s) begin
               state_nx = IDLE;
            end else if (dtack_en) begin
               if (wait_cnt == 8'd0) state_nx = ACK;
               else wait_nx = wait_cnt - 8'd1;
            end else begin
               to_nx = to_cnt + TW'(1);
               if (to_nx == TW'(BERR_TIMEOUT)) begin
                  state_nx = BERR;
                  berr_set = 1'b1;
               end
            end
         end
         ACK: begin
            if (as_s) begin
               state_nx  = IDLE;
               count_inc = 1'b1;
            end
         end
         BERR: begin
            if (as_s) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      led_nx = '0;
      unique case (led_sel)
         2'd0: led_nx = last_addr[23:16];
         2'd1: led_nx = last_addr[15:8];
         2'd2: led_nx = last_addr[7:0];
         2'd3: led_nx = cycle_count[7:0];
         default: led_nx = '0;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (rst) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         to_cnt      <= '0;
         rw_lat      <= 1'b0;
         last_addr   <= '0;
         last_fc     <= '0;
         cycle_count <= '0;
         berr_flag   <= 1'b0;
         dtack_n     <= 1'b1;
         berr_n      <= 1'b1;
         d_out       <= '0;
         d_oe        <= '0;
         led         <= '0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_nx;
         to_cnt   <= to_nx;
         if (cap) begin
            last_addr <= bus.m68k_A;
            last_fc   <= bus.m68k_FC;
            rw_lat    <= rw_s;
         end
         if (count_inc) cycle_count <= cycle_count + 32'd1;
         if (berr_set) berr_flag <= 1'b1;
         // Bus outputs are registered off the next state so they change with it.
         dtack_n <= (state_nx != ACK);
         berr_n  <= (state_nx != BERR);
         if (state_nx == ACK && rw_lat) begin
            d_out <= DATA_WORD;
            d_oe  <= {~uds_s, ~lds_s};
         end else begin
            d_out <= '0;
            d_oe  <= '0;
         end
         led <= led_nx;
      end
   end

   assign bus.m68k_DTACK_n = dtack_n;
   assign bus.m68k_BERR_n  = berr_n;
   assign bus.m68k_D_out   = d_out;
   assign bus.m68k_D_oe    = d_oe;

endmodule
